// File: rtl/a_rom_reader_pkg.sv
// Shared A-matrix types, geometry and ROM word helpers (also used by the MAC datapath).
package a_mat_pkg;

    localparam int unsigned ELEM_W        = 7;
    localparam int unsigned ADDR_W        = 4;
    localparam int unsigned ROWS          = 8;
    localparam int unsigned COLS          = 4;
    localparam int unsigned WORDS_PER_COL = ROWS / 2;
    localparam int unsigned WORD_W        = 2 * ELEM_W;
    localparam int unsigned ROW_W         = $clog2(ROWS);
    localparam int unsigned COL_W         = $clog2(COLS);
    localparam int unsigned WIDX_W        = $clog2(WORDS_PER_COL);

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [COL_W-1:0]  col_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LOAD,
        ST_HI,
        ST_LO,
        ST_DONE
    } state_t;

    // One element beat on the downstream stream.
    typedef struct packed {
        elem_t data;
        row_t  row;
        col_t  col;
        logic  last;
    } elem_beat_t;

    // True when addr is the last ROM word of the scan (col 3 word 3, or word 3 of a single column).
    function automatic logic is_final_addr(input addr_t a, input logic single);
        return (a[WIDX_W-1:0] == WIDX_W'(WORDS_PER_COL - 1)) &&
               (single || (a[ADDR_W-1:WIDX_W] == COL_W'(COLS - 1)));
    endfunction

    // Beat for the element stored in the upper half of ROM word a.
    function automatic elem_beat_t make_hi_beat(input elem_t d, input addr_t a);
        elem_beat_t b;
        b.data = d;
        b.row  = {a[WIDX_W-1:0], 1'b0};
        b.col  = a[ADDR_W-1:WIDX_W];
        b.last = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/a_rom_reader_if.sv
// Valid/ready element stream from the A ROM reader to its consumer.
interface a_rom_reader_if;
    import a_mat_pkg::*;

    logic  elem_valid;
    logic  elem_ready;
    elem_t elem_data;
    row_t  elem_row;
    col_t  elem_col;
    logic  elem_last;

    modport master (
        output elem_valid, elem_data, elem_row, elem_col, elem_last,
        input  elem_ready
    );

    modport slave (
        input  elem_valid, elem_data, elem_row, elem_col, elem_last,
        output elem_ready
    );
endinterface

// File: rtl/a_rom_reader.sv
// Walks the A-matrix ROM (whole matrix or one column), hides the one-cycle
// ROM latency and streams unpacked 7-bit elements with row/column tags.
module a_rom_reader
    import a_mat_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           col_mode,
    input  col_t           col_idx,
    input  logic           abort,
    output addr_t          rom_addr,
    input  word_t          rom_data,
    a_rom_reader_if.master elem,
    output logic           busy,
    output logic           done
);

    state_t     state_q, state_nx;
    addr_t      addr_q, addr_nx;
    word_t      word_q, word_nx;
    logic       single_q, single_nx;
    elem_beat_t beat_q, beat_nx;
    logic       valid_q, valid_nx;
    logic       busy_q, busy_nx;
    logic       done_q, done_nx;

    logic       xfer;
    logic       addr_final;
    logic       cur_final;

    assign xfer       = valid_q & elem.elem_ready;
    assign addr_final = is_final_addr(addr_q, single_q);
    // Word currently being emitted, recovered from the registered row/col tags.
    assign cur_final  = is_final_addr({beat_q.col, beat_q.row[ROW_W-1:1]}, single_q);

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            word_q   <= '0;
            single_q <= 1'b0;
            beat_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            addr_q   <= addr_nx;
            word_q   <= word_nx;
            single_q <= single_nx;
            beat_q   <= beat_nx;
            valid_q  <= valid_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
        end
    end

    // Next-state and next-output logic; abort overrides everything outside IDLE.
    always_comb begin
        state_nx  = state_q;
        addr_nx   = addr_q;
        word_nx   = word_q;
        single_nx = single_q;
        beat_nx   = beat_q;
        valid_nx  = valid_q;
        busy_nx   = busy_q;
        done_nx   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    single_nx = col_mode;
                    addr_nx   = col_mode ? {col_idx, WIDX_W'(0)} : '0;
                    busy_nx   = 1'b1;
                    state_nx  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                word_nx  = rom_data;
                beat_nx  = make_hi_beat(rom_data[WORD_W-1:ELEM_W], addr_q);
                valid_nx = 1'b1;
                if (!addr_final) begin
                    addr_nx = addr_q + ADDR_W'(1);
                end
                state_nx = ST_HI;
            end
            ST_HI: begin
                if (xfer) begin
                    beat_nx.data = word_q[ELEM_W-1:0];
                    beat_nx.row  = {beat_q.row[ROW_W-1:1], 1'b1};
                    beat_nx.last = cur_final;
                    state_nx     = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    if (cur_final) begin
                        valid_nx     = 1'b0;
                        beat_nx.last = 1'b0;
                        done_nx      = 1'b1;
                        state_nx     = ST_DONE;
                    end else begin
                        // rom_addr already points at the next word, so rom_data holds it now.
                        word_nx = rom_data;
                        beat_nx = make_hi_beat(rom_data[WORD_W-1:ELEM_W], addr_q);
                        if (!addr_final) begin
                            addr_nx = addr_q + ADDR_W'(1);
                        end
                        state_nx = ST_HI;
                    end
                end
            end
            ST_DONE: begin
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                valid_nx = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_nx     = ST_IDLE;
            valid_nx     = 1'b0;
            beat_nx.last = 1'b0;
            busy_nx      = 1'b0;
            done_nx      = 1'b0;
        end
    end

    assign rom_addr        = addr_q;
    assign elem.elem_valid = valid_q;
    assign elem.elem_data  = beat_q.data;
    assign elem.elem_row   = beat_q.row;
    assign elem.elem_col   = beat_q.col;
    assign elem.elem_last  = beat_q.last;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
